// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state encoding, instruction
// field positions and default sizing.
package cpu_pkg;

  localparam int unsigned PcWDefault        = 8;
  localparam int unsigned InstrWDefault     = 16;
  localparam int unsigned MemTimeoutDefault = 15;
  localparam logic [3:0]  HaltOpDefault     = 4'hF;

  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned Reg1Msb   = 11;
  localparam int unsigned Reg1Lsb   = 10;
  localparam int unsigned Reg2Msb   = 9;
  localparam int unsigned Reg2Lsb   = 8;
  localparam int unsigned AdrMsb    = 7;
  localparam int unsigned AdrLsb    = 0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StErr    = 3'd7
  } state_e;

endpackage

// File: rtl/seq_wait_timer.sv
// 4-bit wait-cycle counter shared by the FETCH and MEM handshakes; timeout flags the
// last permitted wait cycle.
module seq_wait_timer #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [3:0] LastCnt = 4'(Timeout - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == LastCnt);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/writeback controller: owns PC and IR, sequences memories, ALU
// strobe and register write-back, and traps halt opcodes and handshake timeouts.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W        = PcWDefault,
  parameter int unsigned     INSTR_W     = InstrWDefault,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]      HALT_OP     = HaltOpDefault,
  parameter int unsigned     MEM_TIMEOUT = MemTimeoutDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               dec_ram_read,
  input  logic               dec_reg_write,
  input  logic               dec_pc_jump,
  input  logic [7:0]         dec_ram_adr,
  input  logic               branch_cond,
  output logic [INSTR_W-1:0] instr,
  output logic               alu_en,
  output logic               dmem_req,
  output logic [7:0]         dmem_addr,
  input  logic               dmem_ready,
  output logic               reg_we,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        retired,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [15:0]         retired_q, retired_d;
  logic                tmr_clr, tmr_en, tmr_timeout;

  // Counter is held clear outside the two wait states, so every entry starts at zero.
  assign tmr_clr = !((state_q == StFetch) || (state_q == StMem));

  seq_wait_timer #(
    .Timeout (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .timeout (tmr_timeout)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    tmr_en    = 1'b0;
    unique case (state_q)
      StIdle, StHalt, StErr: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end else if (tmr_timeout) begin
          state_d = StErr;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StDecode: begin
        state_d = (ir_q[OpcodeMsb:OpcodeLsb] == HALT_OP) ? StHalt : StExec;
      end
      StExec: begin
        state_d = dec_ram_read ? StMem : StWb;
      end
      StMem: begin
        if (dmem_ready) begin
          state_d = StWb;
        end else if (tmr_timeout) begin
          state_d = StErr;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StWb: begin
        pc_d      = (dec_pc_jump && branch_cond) ? PC_W'(dec_ram_adr) : pc_q + PC_W'(1);
        retired_d = retired_q + 16'd1;
        state_d   = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign instr     = ir_q;
  assign alu_en    = (state_q == StExec);
  assign dmem_req  = (state_q == StMem);
  assign dmem_addr = dec_ram_adr;
  assign reg_we    = (state_q == StWb) && dec_reg_write;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign busy      = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec) ||
                     (state_q == StMem) || (state_q == StWb);
  assign halted    = (state_q == StHalt);
  assign err       = (state_q == StErr);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction timing model plus pc/retired
// arithmetic reference, directed scenarios and a randomized instruction stream.
module tb_cpu_sequencer;

  localparam int MemTimeout = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        dec_ram_read = 1'b0;
  logic        dec_reg_write = 1'b0;
  logic        dec_pc_jump = 1'b0;
  logic [7:0]  dec_ram_adr = '0;
  logic        branch_cond = 1'b0;
  logic [15:0] instr;
  logic        alu_en;
  logic        dmem_req;
  logic [7:0]  dmem_addr;
  logic        dmem_ready = 1'b0;
  logic        reg_we;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic        busy;
  logic        halted;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  exp_pc  = '0;
  logic [15:0] exp_ret = '0;

  always #5 clk = ~clk;

  cpu_sequencer u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .dec_ram_read  (dec_ram_read),
    .dec_reg_write (dec_reg_write),
    .dec_pc_jump   (dec_pc_jump),
    .dec_ram_adr   (dec_ram_adr),
    .branch_cond   (branch_cond),
    .instr         (instr),
    .alu_en        (alu_en),
    .dmem_req      (dmem_req),
    .dmem_addr     (dmem_addr),
    .dmem_ready    (dmem_ready),
    .reg_we        (reg_we),
    .pc            (pc),
    .retired       (retired),
    .busy          (busy),
    .halted        (halted),
    .err           (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction through, starting in its first FETCH cycle; the bench
  // plays control unit (opcode 1 load, 2 jump, 4/7 register ops, F halt).
  task automatic run_instr(input logic [15:0] ins, input int iwait, input int dwait,
                           input logic cond, input logic poke_start);
    logic [3:0] op;
    logic [7:0] adr;
    logic       rd, we, jmp;
    op  = ins[15:12];
    adr = ins[7:0];
    rd  = (op == 4'h1);
    we  = (op == 4'h1) || (op == 4'h4) || (op == 4'h7);
    jmp = (op == 4'h2);
    dec_ram_read = rd; dec_reg_write = we; dec_pc_jump = jmp; dec_ram_adr = adr;
    branch_cond = cond; imem_rdata = ins; start = poke_start;
    for (int k = 0; k <= iwait; k++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch: req=%b addr=%h busy=%b, required req=1 addr=%h busy=1",
                 imem_req, imem_addr, busy, exp_pc);
      end
      imem_ready = (k == iwait);
      step();
    end
    imem_ready = 1'b0;
    start = 1'b0;
    n_tests++;
    if (instr !== ins || imem_req !== 1'b0 || alu_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL decode: instr=%h req=%b alu=%b busy=%b, required instr=%h 0 0 1",
               instr, imem_req, alu_en, busy, ins);
    end
    step();
    if (op == 4'hF) begin
      n_tests++;
      if (halted !== 1'b1 || alu_en !== 1'b0 || reg_we !== 1'b0 || pc !== exp_pc ||
          retired !== exp_ret || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_entry: halted=%b alu=%b we=%b pc=%h ret=%0d busy=%b, required 1 0 0 %h %0d 0",
                 halted, alu_en, reg_we, pc, retired, busy, exp_pc, exp_ret);
      end
      return;
    end
    n_tests++;
    if (alu_en !== 1'b1 || reg_we !== 1'b0 || dmem_req !== 1'b0 || instr !== ins) begin
      n_fail++;
      $display("FAIL exec: alu=%b we=%b dreq=%b instr=%h, required 1 0 0 %h",
               alu_en, reg_we, dmem_req, instr, ins);
    end
    step();
    if (rd) begin
      for (int k = 0; k <= dwait; k++) begin
        n_tests++;
        if (dmem_req !== 1'b1 || dmem_addr !== adr || alu_en !== 1'b0) begin
          n_fail++;
          $display("FAIL mem: dreq=%b daddr=%h alu=%b, required dreq=1 daddr=%h alu=0",
                   dmem_req, dmem_addr, alu_en, adr);
        end
        dmem_ready = (k == dwait);
        step();
      end
      dmem_ready = 1'b0;
    end
    n_tests++;
    if (reg_we !== we || alu_en !== 1'b0 || dmem_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wb: we=%b alu=%b dreq=%b busy=%b, required we=%b 0 0 1",
               reg_we, alu_en, dmem_req, busy, we);
    end
    step();
    exp_pc  = (jmp && cond) ? adr : exp_pc + 8'd1;
    exp_ret = exp_ret + 16'd1;
    n_tests++;
    if (pc !== exp_pc || retired !== exp_ret || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL retire: pc=%h ret=%0d req=%b, required pc=%h ret=%0d req=1",
               pc, retired, imem_req, exp_pc, exp_ret);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_pc = 8'h00;
    n_tests++;
    if (imem_req !== 1'b1 || pc !== exp_pc || halted !== 1'b0 || err !== 1'b0 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start: req=%b pc=%h halted=%b err=%b busy=%b, required 1 00 0 0 1",
               imem_req, pc, halted, err, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0 || pc !== 8'h00 ||
        retired !== 16'd0 || imem_req !== 1'b0 || alu_en !== 1'b0 || reg_we !== 1'b0 ||
        dmem_req !== 1'b0 || instr !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset: busy=%b halted=%b err=%b pc=%h ret=%0d req=%b alu=%b we=%b dreq=%b ir=%h, required all zero",
               busy, halted, err, pc, retired, imem_req, alu_en, reg_we, dmem_req, instr);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    n_tests++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b req=%b, required 0 0", busy, imem_req);
    end
  endtask

  task automatic test_basic();
    do_start();
    run_instr(16'h4D00, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ram_wait();
    run_instr(16'h113C, 1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_jump();
    run_instr(16'h2020, 0, 0, 1'b1, 1'b0);
    run_instr(16'h2020, 2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_halt();
    run_instr(16'hF000, 1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if (halted !== 1'b1 || alu_en !== 1'b0 || reg_we !== 1'b0 || pc !== exp_pc ||
          retired !== exp_ret) begin
        n_fail++;
        $display("FAIL halt_hold: halted=%b alu=%b we=%b pc=%h ret=%0d, required 1 0 0 %h %0d",
                 halted, alu_en, reg_we, pc, retired, exp_pc, exp_ret);
      end
    end
    do_start();
  endtask

  task automatic test_timeout();
    imem_ready = 1'b0;
    for (int k = 0; k < MemTimeout; k++) begin
      n_tests++;
      if (imem_req !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait[%0d]: req=%b err=%b, required req=1 err=0",
                 k, imem_req, err);
      end
      step();
    end
    n_tests++;
    if (err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b req=%b busy=%b, required 1 0 0", err, imem_req, busy);
    end
    step();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
    do_start();
  endtask

  task automatic test_wrap();
    run_instr(16'h20FF, 0, 0, 1'b1, 1'b0);
    run_instr(16'h4000, 0, 0, 1'b0, 1'b0);
    n_tests++;
    if (pc !== 8'h00) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h, required 00", pc);
    end
  endtask

  task automatic test_reset_mid();
    dec_ram_read = 1'b1; dec_reg_write = 1'b1; dec_pc_jump = 1'b0; dec_ram_adr = 8'h55;
    imem_rdata = 16'h1055; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    step();
    step();
    n_tests++;
    if (dmem_req !== 1'b1 || dmem_addr !== 8'h55) begin
      n_fail++;
      $display("FAIL mid_mem: dreq=%b daddr=%h, required 1 55", dmem_req, dmem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_pc = 8'h00;
    exp_ret = 16'd0;
    n_tests++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || retired !== exp_ret || pc !== exp_pc ||
        instr !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: dreq=%b busy=%b ret=%0d pc=%h ir=%h, required 0 0 0 00 0000",
               dmem_req, busy, retired, pc, instr);
    end
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b req=%b dreq=%b, required 0 0 0",
               busy, imem_req, dmem_req);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] ins;
    do_start();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 4'h1;
        3, 4:    op = 4'h2;
        5, 6:    op = 4'h4;
        7:       op = 4'h7;
        8:       op = 4'h0;
        default: op = 4'hF;
      endcase
      ins = {op, 12'($urandom)};
      run_instr(ins, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom),
                1'($urandom));
      if (op == 4'hF) do_start();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ram_wait();
    test_jump();
    test_halt();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
